bp_update_arbiter: RTL and testbench

//  Schedules branch-outcome feedback into the predictor's single update port
//  (fb_ena / fb_taken_sta / fb_pc). Two requesters feed it:
//    - A: execute-stage branch resolution.
//    - B: commit-stage resolution.

---
 rtl/bp_update_arbiter_pkg.sv | 20 ++
 rtl/bp_fb_fifo.sv | 50 +++++
 rtl/bp_update_arbiter.sv | 91 +++++++++
 tb/tb_bp_update_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_arbiter_pkg.sv
// Shared types for the branch-predictor update arbiter: address type,
// FIFO entry layout and round-robin priority encoding.
package bp_update_arbiter_pkg;

  // Width of the codebase-wide branch address type
  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  taken;
    addr_t pc;
  } fb_entry_t;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } rr_pri_e;

endpackage

// File: rtl/bp_fb_fifo.sv
// Feedback FIFO: two write ports (slot tail and tail+1), one read port,
// registered head output and occupancy count.
module bp_fb_fifo
  import bp_update_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr0_en,
  input  fb_entry_t        wr0_data,
  input  logic             wr1_en,
  input  fb_entry_t        wr1_data,
  input  logic             rd_en,
  output fb_entry_t        rd_data,
  output logic [PTR_W:0]   count
);

  fb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   n_wr;

  assign n_wr    = (PTR_W+1)'(wr0_en) + (PTR_W+1)'(wr1_en);
  assign rd_data = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr0_en) mem[tail] <= wr0_data;
      if (wr1_en) mem[tail + PTR_W'(1)] <= wr1_data;
      tail  <= tail + PTR_W'(n_wr);
      if (rd_en) head <= head + PTR_W'(1);
      count <= count + n_wr - (PTR_W+1)'(rd_en);
    end
  end

endmodule

// File: rtl/bp_update_arbiter.sv
// Round-robin arbiter merging execute (A) and commit (B) branch feedback
// into a FIFO that drains into the predictor update port when pd_ena is high.
module bp_update_arbiter
  import bp_update_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           pd_ena,
  input  logic           a_valid,
  input  logic           a_taken,
  input  addr_t          a_pc,
  output logic           a_ready,
  input  logic           b_valid,
  input  logic           b_taken,
  input  addr_t          b_pc,
  output logic           b_ready,
  output logic           fb_ena,
  output logic           fb_taken_sta,
  output addr_t          fb_pc,
  output logic [PTR_W:0] q_count
);

  rr_pri_e        rr_q, rr_d;
  logic [PTR_W:0] free;
  logic           a_first;
  logic           pop;
  fb_entry_t      a_ent, b_ent, wr0_data, wr1_data, head_ent;

  // Free space uses the registered count: a same-cycle pop never adds room
  assign free = (PTR_W+1)'(DEPTH) - q_count;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    rr_d    = rr_q;
    if (!flush) begin
      if (a_valid && b_valid) begin
        if (free >= (PTR_W+1)'(2)) begin
          a_ready = 1'b1;
          b_ready = 1'b1;
        end else if (free == (PTR_W+1)'(1)) begin
          if (rr_q == PRI_A) a_ready = 1'b1;
          else               b_ready = 1'b1;
          rr_d = (rr_q == PRI_A) ? PRI_B : PRI_A;
        end
      end else if (a_valid && free != '0) begin
        a_ready = 1'b1;
      end else if (b_valid && free != '0) begin
        b_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= PRI_A;
    else     rr_q <= rr_d;
  end

  // The priority source takes the tail slot when both are granted
  assign a_ent    = '{taken: a_taken, pc: a_pc};
  assign b_ent    = '{taken: b_taken, pc: b_pc};
  assign a_first  = a_ready && (!b_ready || rr_q == PRI_A);
  assign wr0_data = a_first ? a_ent : b_ent;
  assign wr1_data = a_first ? b_ent : a_ent;
  assign pop      = pd_ena && (q_count != '0) && !flush;

  bp_fb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .wr0_en   (a_ready | b_ready),
    .wr0_data (wr0_data),
    .wr1_en   (a_ready & b_ready),
    .wr1_data (wr1_data),
    .rd_en    (pop),
    .rd_data  (head_ent),
    .count    (q_count)
  );

  assign fb_ena       = (q_count != '0);
  assign fb_taken_sta = head_ent.taken;
  assign fb_pc        = head_ent.pc;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Self-checking bench: directed scenarios against constants, then random
// traffic against a queue-based reference model.
module tb_bp_update_arbiter;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk = 1'b0;
  logic        rst, flush, pd_ena;
  logic        a_valid, a_taken, b_valid, b_taken;
  logic [31:0] a_pc, b_pc;
  logic        a_ready, b_ready, fb_ena, fb_taken_sta;
  logic [31:0] fb_pc;
  logic [PTR_W:0] q_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bp_update_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .pd_ena(pd_ena),
    .a_valid(a_valid), .a_taken(a_taken), .a_pc(a_pc), .a_ready(a_ready),
    .b_valid(b_valid), .b_taken(b_taken), .b_pc(b_pc), .b_ready(b_ready),
    .fb_ena(fb_ena), .fb_taken_sta(fb_taken_sta), .fb_pc(fb_pc), .q_count(q_count)
  );

  // Reference model: queue of {taken, pc} plus which requester has priority
  logic [32:0] mq[$];
  bit          m_pri_b = 0;

  // Snapshot of DUT outputs and model expectations for the cycle just ticked
  logic        obs_ar, obs_br, obs_fe, obs_ft;
  logic [31:0] obs_pc;
  logic [PTR_W:0] obs_cnt;
  logic        exp_ar, exp_br, exp_fe, exp_ft;
  logic [31:0] exp_pc;
  int          exp_cnt;

  task automatic tick();
    int  free;
    bit  pop;
    #2;
    obs_ar = a_ready; obs_br = b_ready; obs_fe = fb_ena; obs_ft = fb_taken_sta;
    obs_pc = fb_pc;   obs_cnt = q_count;
    free    = DEPTH - mq.size();
    exp_cnt = mq.size();
    exp_fe  = (mq.size() != 0);
    exp_ft  = exp_fe ? mq[0][32] : 1'b0;
    exp_pc  = exp_fe ? mq[0][31:0] : 32'h0;
    exp_ar = 0; exp_br = 0;
    if (!flush) begin
      if (a_valid && b_valid) begin
        if (free >= 2) begin exp_ar = 1; exp_br = 1; end
        else if (free == 1) begin
          if (m_pri_b) exp_br = 1; else exp_ar = 1;
        end
      end else begin
        exp_ar = a_valid && free >= 1;
        exp_br = b_valid && free >= 1;
      end
    end
    pop = pd_ena && mq.size() != 0 && !flush;
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_pri_b = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (exp_ar && exp_br) begin
        if (m_pri_b) begin mq.push_back({b_taken, b_pc}); mq.push_back({a_taken, a_pc}); end
        else         begin mq.push_back({a_taken, a_pc}); mq.push_back({b_taken, b_pc}); end
      end else if (exp_ar) mq.push_back({a_taken, a_pc});
      else if (exp_br) mq.push_back({b_taken, b_pc});
      if (a_valid && b_valid && free == 1) m_pri_b = !m_pri_b;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; pd_ena = 0;
    a_valid = 0; a_taken = 0; a_pc = '0;
    b_valid = 0; b_taken = 0; b_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    tick();
    n_cmp++;
    if ({obs_fe, obs_ft, obs_pc, obs_cnt, obs_ar, obs_br} !== '0) begin
      n_fail++;
      $display("FAIL reset: fe=%b ft=%b pc=%h cnt=%0d ar=%b br=%b, want all 0",
               obs_fe, obs_ft, obs_pc, obs_cnt, obs_ar, obs_br);
    end
  endtask

  task automatic test_single();
    pd_ena = 1; a_valid = 1; a_pc = 32'h100; a_taken = 1;
    tick();
    n_cmp++;
    if (obs_ar !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", obs_ar); end
    a_valid = 0;
    tick();
    n_cmp++;
    if ({obs_fe, obs_ft, obs_pc} !== {1'b1, 1'b1, 32'h100}) begin
      n_fail++; $display("FAIL single_fb: fe=%b ft=%b pc=%h want 1 1 00000100", obs_fe, obs_ft, obs_pc);
    end
    tick();
    n_cmp++;
    if (obs_fe !== 1'b0) begin n_fail++; $display("FAIL single_drained: fe=%b want 0", obs_fe); end
  endtask

  task automatic test_fill_drain();
    pd_ena = 0; a_valid = 1; a_taken = 0;
    for (int i = 0; i < 4; i++) begin
      a_pc = 32'h10 + 32'(4 * i);
      tick();
      n_cmp++;
      if (obs_ar !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want 1", i, obs_ar); end
    end
    a_pc = 32'h99;
    tick();
    n_cmp++;
    if ({obs_cnt, obs_ar} !== {3'd4, 1'b0}) begin
      n_fail++; $display("FAIL full_block: cnt=%0d ar=%b want 4 0", obs_cnt, obs_ar);
    end
    a_valid = 0; pd_ena = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({obs_fe, obs_pc} !== {1'b1, 32'h10 + 32'(4 * i)}) begin
        n_fail++; $display("FAIL drain[%0d]: fe=%b pc=%h want 1 %h", i, obs_fe, obs_pc, 32'h10 + 32'(4 * i));
      end
    end
    tick();
    n_cmp++;
    if ({obs_fe, obs_cnt} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL drain_empty: fe=%b cnt=%0d want 0 0", obs_fe, obs_cnt);
    end
  endtask

  task automatic test_both();
    pd_ena = 1; a_valid = 1; b_valid = 1; a_pc = 32'h20; b_pc = 32'h40; a_taken = 0; b_taken = 1;
    tick();
    n_cmp++;
    if ({obs_ar, obs_br, obs_cnt} !== {1'b1, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL both_ready: ar=%b br=%b cnt=%0d want 1 1 0", obs_ar, obs_br, obs_cnt);
    end
    a_valid = 0; b_valid = 0;
    tick();
    n_cmp++;
    if ({obs_cnt, obs_pc, obs_ft} !== {3'd2, 32'h20, 1'b0}) begin
      n_fail++; $display("FAIL both_first: cnt=%0d pc=%h ft=%b want 2 00000020 0", obs_cnt, obs_pc, obs_ft);
    end
    tick();
    n_cmp++;
    if ({obs_cnt, obs_pc, obs_ft} !== {3'd1, 32'h40, 1'b1}) begin
      n_fail++; $display("FAIL both_second: cnt=%0d pc=%h ft=%b want 1 00000040 1", obs_cnt, obs_pc, obs_ft);
    end
    tick();
  endtask

  task automatic fill_a(input int n, input logic [31:0] base);
    pd_ena = 0; b_valid = 0; a_valid = 1;
    for (int i = 0; i < n; i++) begin
      a_pc = base + 32'(4 * i);
      tick();
    end
    a_valid = 0;
  endtask

  task automatic test_contention();
    fill_a(3, 32'h50);
    a_valid = 1; b_valid = 1; a_pc = 32'h60; b_pc = 32'h70;
    tick();
    n_cmp++;
    if ({obs_ar, obs_br, obs_cnt} !== {1'b1, 1'b0, 3'd3}) begin
      n_fail++; $display("FAIL contend_a: ar=%b br=%b cnt=%0d want 1 0 3", obs_ar, obs_br, obs_cnt);
    end
    tick();
    n_cmp++;
    if ({obs_ar, obs_br, obs_cnt} !== {1'b0, 1'b0, 3'd4}) begin
      n_fail++; $display("FAIL contend_full: ar=%b br=%b cnt=%0d want 0 0 4", obs_ar, obs_br, obs_cnt);
    end
    pd_ena = 1;
    tick();
    n_cmp++;
    if ({obs_ar, obs_br} !== 2'b00) begin
      n_fail++; $display("FAIL pop_no_space: ar=%b br=%b want 0 0", obs_ar, obs_br);
    end
    pd_ena = 0;
    tick();
    n_cmp++;
    if ({obs_ar, obs_br, obs_cnt} !== {1'b0, 1'b1, 3'd3}) begin
      n_fail++; $display("FAIL contend_b: ar=%b br=%b cnt=%0d want 0 1 3", obs_ar, obs_br, obs_cnt);
    end
    a_valid = 0; b_valid = 0; pd_ena = 1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] want;
      want = (i < 2) ? 32'h54 + 32'(4 * i) : ((i == 2) ? 32'h60 : 32'h70);
      tick();
      n_cmp++;
      if (obs_pc !== want) begin n_fail++; $display("FAIL contend_order[%0d]: pc=%h want %h", i, obs_pc, want); end
    end
  endtask

  task automatic test_flush();
    fill_a(3, 32'h80);
    flush = 1; a_valid = 1; a_pc = 32'h90; pd_ena = 1;
    tick();
    n_cmp++;
    if ({obs_ar, obs_cnt} !== {1'b0, 3'd3}) begin
      n_fail++; $display("FAIL flush_block: ar=%b cnt=%0d want 0 3", obs_ar, obs_cnt);
    end
    flush = 0; a_valid = 0; pd_ena = 0;
    tick();
    n_cmp++;
    if ({obs_cnt, obs_fe} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL flush_clear: cnt=%0d fe=%b want 0 0", obs_cnt, obs_fe);
    end
  endtask

  task automatic test_reset_flush();
    fill_a(3, 32'hA0);
    a_valid = 1; b_valid = 1; a_pc = 32'hB0; b_pc = 32'hC0; a_taken = 1;
    tick();  // contention: A granted, priority moves to B
    rst = 1; flush = 1;
    tick();
    n_cmp++;
    if ({obs_ar, obs_br} !== 2'b00) begin
      n_fail++; $display("FAIL rst_flush_ready: ar=%b br=%b want 0 0", obs_ar, obs_br);
    end
    rst = 0; flush = 0; a_valid = 0; b_valid = 0;
    tick();
    n_cmp++;
    if ({obs_fe, obs_ft, obs_pc, obs_cnt, obs_ar, obs_br} !== '0) begin
      n_fail++; $display("FAIL rst_flush_state: fe=%b ft=%b pc=%h cnt=%0d ar=%b br=%b want all 0",
                         obs_fe, obs_ft, obs_pc, obs_cnt, obs_ar, obs_br);
    end
    fill_a(3, 32'hD0);
    a_valid = 1; b_valid = 1;
    tick();
    n_cmp++;
    if ({obs_ar, obs_br} !== 2'b10) begin
      n_fail++; $display("FAIL rst_pri_a: ar=%b br=%b want 1 0", obs_ar, obs_br);
    end
    a_valid = 0; b_valid = 0; flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(63) == 0);
      flush   = ($urandom_range(15) == 0);
      pd_ena  = ($urandom_range(2) == 0);
      a_valid = $urandom_range(1);
      b_valid = $urandom_range(1);
      a_taken = $urandom_range(1);
      b_taken = $urandom_range(1);
      a_pc    = $urandom;
      b_pc    = $urandom;
      tick();
      n_cmp++;
      if ({obs_ar, obs_br, obs_fe} !== {exp_ar, exp_br, exp_fe} || int'(obs_cnt) != exp_cnt) begin
        n_fail++;
        $display("FAIL rand_ctl[%0d]: ar=%b br=%b fe=%b cnt=%0d want %b %b %b %0d",
                 c, obs_ar, obs_br, obs_fe, obs_cnt, exp_ar, exp_br, exp_fe, exp_cnt);
      end
      if (exp_fe) begin
        n_cmp++;
        if ({obs_ft, obs_pc} !== {exp_ft, exp_pc}) begin
          n_fail++;
          $display("FAIL rand_head[%0d]: ft=%b pc=%h want %b %h", c, obs_ft, obs_pc, exp_ft, exp_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_both();
    test_contention();
    test_flush();
    test_reset_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
